rsub_divider: RTL
=================

# rsub_divider

Sequential unsigned 16-bit divider using repeated subtraction. It is the inverse companion of the multiply-by-repeated-addition datapath. A controller FSM subtracts the divisor from a running remainder and counts iterations until the remainder is smaller than the divisor. It sits beside the multiplier as a standalone arithmetic unit driven by a start/done handshake from the system controller.

## Interface
- W, 16, operand/result width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  W  numerator, captured on accepted start
- divisor  input  W  denominator, captured on accepted start
- quotient  output  W  result, valid while done=1 and held until next accepted start
- remainder  output  W  result, same validity as quotient
- busy  output  1  high from the edge after the accepted start until DONE is entered
- done  output  1  one-cycle pulse marking valid results
- div_by_zero  output  1  set with done when the captured divisor = 0; held with the results

## Operation
- Datapath registers:
  - R (remainder, W bits)
  - D (divisor, W bits)
  - Q (quotient, W bits)
- Combinational status: `geq = (R >= D)` and `dz = (D == 0)`.
- FSM states:
  - IDLE: busy=0, done=0. On start:
    - R <= dividend
    - D <= divisor
    - Q <= 0
    - div_by_zero <= 0
    - go to RUN.
  - RUN: busy=1.
    - If dz: div_by_zero <= 1, go to DONE.
    - Else if geq: R <= R - D, Q <= Q + 1, stay in RUN.
    - Else: go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle. Behaves as IDLE for start, so back-to-back operations are allowed. With no start, go to IDLE.
- Results:
  - Normal: quotient = Q and remainder = R, with dividend = Q*divisor + R and R < divisor.
  - Divide by zero: quotient = 0, remainder = dividend, div_by_zero = 1.
- Q cannot overflow because the quotient is at most the dividend. The subtractor is W bits with no borrow out, since it only fires when geq.
- start in RUN is ignored, and the operands are not re-sampled.
- Outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Timing
- Edge numbering: edge 0 is the edge that samples an accepted start.
- Normal case: done rises after edge q+1, where q is the true quotient. Examples: 100/7 gives done after edge 15; 5/9 gives done after edge 1.
- Divide by zero: done rises after edge 1.
- Worst case: 65535/1 gives done after edge 65536.
- busy is high after edges 0..q and low during done.
- Reset:
  - rst is synchronous and dominates all other inputs.
  - Next state is IDLE, and all outputs and registers become 0.
  - rst mid-RUN aborts the operation with no done pulse.
- start and rst asserted together: rst wins, and the start is lost.
- start during the DONE cycle: accepted. done is 0 in the following cycle and results are overwritten.

## Structure
- Package rsub_pkg holds:
  - the width constant `W=16`
  - the state enum {IDLE, RUN, DONE}
- One sub-module, rsub_datapath, holds:
  - the R, D and Q registers
  - the subtractor and incrementer
  - the >= comparator and the zero detect on D
- rsub_datapath takes load/decrement controls and returns geq and dz. The controller FSM stays in rsub_divider.

## Test plan
- 100/7 → quotient=14, remainder=2, div_by_zero=0; done a single pulse after edge 15; busy high for edges 0..14.
- 5/9 → quotient=0, remainder=5; done after edge 1. 42/42 → quotient=1, remainder=0; done after edge 2.
- 1234/0 → div_by_zero=1, quotient=0, remainder=1234; done after edge 1. Then 0/3 → quotient=0, remainder=0, div_by_zero cleared.
- 65535/1 → quotient=65535, remainder=0; done after edge 65536; no wrap of Q.
- 200/3 with start re-pulsed at edge 10 using 9/2 → ignored; result is quotient=66, remainder=2. A start in the done cycle with 9/2 → quotient=4, remainder=1.
- 1000/1, rst asserted at edge 50 → state IDLE, all outputs 0, no done pulse. A subsequent 17/5 → quotient=3, remainder=2.

Source files
------------

// File: rtl/rsub_pkg.sv
// rtl/rsub_pkg.sv - shared width and controller state encoding for the repeated-subtraction divider.
package rsub_pkg;

  localparam int W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rsub_datapath.sv
// rtl/rsub_datapath.sv - remainder/divisor/quotient registers with subtract, increment and compare.
module rsub_datapath
  import rsub_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] r,
  output logic [W-1:0] q,
  output logic         geq,
  output logic         dz
);

  logic [W-1:0] d;

  // step is only asserted while r >= d, so the subtract never borrows
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      d <= '0;
      q <= '0;
    end else if (load) begin
      r <= dividend;
      d <= divisor;
      q <= '0;
    end else if (step) begin
      r <= r - d;
      q <= q + W'(1);
    end
  end

  assign geq = (r >= d);
  assign dz  = (d == '0);

endmodule

// File: rtl/rsub_divider.sv
// rtl/rsub_divider.sv - start/done controlled unsigned divider by repeated subtraction.
module rsub_divider
  import rsub_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  state_t state, next_state;
  logic   load, step, set_dz;
  logic   geq, dz;

  rsub_datapath u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .dividend (dividend),
    .divisor  (divisor),
    .r        (remainder),
    .q        (quotient),
    .geq      (geq),
    .dz       (dz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div_by_zero <= 1'b0;
    end else begin
      state <= next_state;
      if (load)
        div_by_zero <= 1'b0;
      else if (set_dz)
        div_by_zero <= 1'b1;
    end
  end

  // DONE accepts a new start exactly like IDLE so operations can run back to back
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    set_dz     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (dz) begin
          set_dz     = 1'b1;
          next_state = DONE;
        end else if (geq) begin
          step = 1'b1;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
